// File: rtl/mmio_hub_pkg.sv
// Shared I/O map constants and decode selector for the MMIO hub.
package mmio_hub_pkg;

  localparam logic [7:0] SPRITE_BASE = 8'h00;
  localparam logic [7:0] BTN_BASE    = 8'h80;
  localparam logic [7:0] FRAME_OFS   = 8'hC0;
  localparam logic [7:0] GPO_OFS     = 8'hC1;
  localparam logic [7:0] COMMIT_OFS  = 8'hC2;

  localparam int unsigned PLAYER_STRIDE = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SPRITE,
    SEL_BTN,
    SEL_FRAME,
    SEL_GPO,
    SEL_COMMIT
  } io_sel_e;

endpackage

// File: rtl/mmio_hub_button_debouncer.sv
// Per-bit button debouncer: 2-flop synchroniser (inverted, 1 = pressed)
// followed by a saturating stability counter per bit.
module button_debouncer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] pressed
);

  localparam int unsigned     CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      pressed <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= ~raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == pressed[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          pressed[i] <= sync2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: RAM pass-through, debounced buttons, GPIO output,
// double-buffered sprite descriptors committed on vsync, frame counter.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 13,
  parameter int unsigned BTN_WIDTH       = 16,
  parameter int unsigned SPRITE_WORDS    = 4,
  parameter int unsigned GPIO_OUT_WIDTH  = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [ADDR_WIDTH-1:0]                  address,
  input  logic [31:0]                            data_in,
  input  logic                                   wren,
  output logic [31:0]                            data_out,
  output logic                                   ram_wren,
  input  logic [31:0]                            ram_q,
  input  logic [NUM_PLAYERS*BTN_WIDTH-1:0]       gpio,
  output logic [GPIO_OUT_WIDTH-1:0]              gpio_out,
  input  logic                                   vsync,
  output logic [NUM_PLAYERS*SPRITE_WORDS*32-1:0] player_vga,
  output logic [31:0]                            frame_count
);

  localparam int unsigned NUM_WORDS = NUM_PLAYERS * SPRITE_WORDS;

  logic                             io;
  logic                             io_we;
  logic [7:0]                       ofs;
  logic                             unused_addr;
  io_sel_e                          sel;
  logic [31:0]                      spr_p;
  logic [31:0]                      spr_w;
  logic [31:0]                      btn_p;
  logic [31:0]                      sel_idx;
  logic [31:0]                      rdata;
  logic [NUM_PLAYERS*BTN_WIDTH-1:0] btn;
  logic [31:0]                      shadow [NUM_WORDS];
  logic                             pending;
  logic                             io_q;
  logic [31:0]                      io_rdata_q;
  logic [2:0]                       vs_sync;
  logic                             vsync_rise;

  assign io          = address[ADDR_WIDTH-1];
  assign ofs         = address[7:0];
  assign unused_addr = ^address[ADDR_WIDTH-2:8];
  assign io_we       = wren & io;
  assign ram_wren    = wren & ~io;
  assign data_out    = io_q ? io_rdata_q : ram_q;
  assign vsync_rise  = vs_sync[1] & ~vs_sync[2];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_deb
    button_debouncer #(
      .WIDTH  (BTN_WIDTH),
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clock   (clock),
      .reset   (reset),
      .raw     (gpio[p*BTN_WIDTH +: BTN_WIDTH]),
      .pressed (btn[p*BTN_WIDTH +: BTN_WIDTH])
    );
  end

  always_comb begin
    sel     = SEL_NONE;
    spr_p   = 32'(ofs - SPRITE_BASE) / PLAYER_STRIDE;
    spr_w   = 32'(ofs - SPRITE_BASE) % PLAYER_STRIDE;
    btn_p   = 32'(ofs - BTN_BASE);
    sel_idx = spr_p * SPRITE_WORDS + spr_w;
    if (ofs < BTN_BASE) begin
      if (spr_p < NUM_PLAYERS && spr_w < SPRITE_WORDS) sel = SEL_SPRITE;
    end else if (ofs < FRAME_OFS) begin
      if (btn_p < NUM_PLAYERS) sel = SEL_BTN;
    end else begin
      case (ofs)
        FRAME_OFS:  sel = SEL_FRAME;
        GPO_OFS:    sel = SEL_GPO;
        COMMIT_OFS: sel = SEL_COMMIT;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_SPRITE: begin
        for (int unsigned i = 0; i < NUM_WORDS; i++)
          if (sel_idx == i) rdata = shadow[i];
      end
      SEL_BTN: begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++)
          if (btn_p == p) rdata = 32'(btn[p*BTN_WIDTH +: BTN_WIDTH]);
      end
      SEL_FRAME:  rdata = frame_count;
      SEL_GPO:    rdata = 32'(gpio_out);
      SEL_COMMIT: rdata = {31'b0, pending};
      default:    rdata = '0;
    endcase
  end

  // io_q resets high so the zeroed read register, not ram_q, drives data_out
  // until the first real address has been sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
      player_vga  <= '0;
      pending     <= 1'b0;
      frame_count <= '0;
      gpio_out    <= '0;
      io_q        <= 1'b1;
      io_rdata_q  <= '0;
      vs_sync     <= '0;
    end else begin
      vs_sync    <= {vs_sync[1:0], vsync};
      io_q       <= io;
      io_rdata_q <= rdata;
      if (vsync_rise) begin
        frame_count <= frame_count + 32'd1;
        if (pending) begin
          for (int unsigned i = 0; i < NUM_WORDS; i++) player_vga[i*32 +: 32] <= shadow[i];
          pending <= 1'b0;
        end
      end
      // Later assignment wins: a commit landing on a vsync edge stays pending.
      if (io_we) begin
        case (sel)
          SEL_SPRITE: begin
            for (int unsigned i = 0; i < NUM_WORDS; i++)
              if (sel_idx == i) shadow[i] <= data_in;
          end
          SEL_GPO:    gpio_out <= data_in[GPIO_OUT_WIDTH-1:0];
          SEL_COMMIT: if (data_in[0]) pending <= 1'b1;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub with a map-level reference model.
module tb_mmio_hub;

  localparam int NP = 2;
  localparam int SW = 4;
  localparam int BW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [12:0]       address;
  logic [31:0]       data_in;
  logic              wren;
  logic [31:0]       data_out;
  logic              ram_wren;
  logic [31:0]       ram_q;
  logic [NP*BW-1:0]  gpio;
  logic [2:0]        gpio_out;
  logic              vsync;
  logic [NP*SW*32-1:0] player_vga;
  logic [31:0]       frame_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_shadow [NP][SW];
  logic [31:0] m_active [NP][SW];
  logic [15:0] m_btn [NP];
  logic        m_pending;
  logic [31:0] m_frame;
  logic [2:0]  m_gpo;

  mmio_hub #(
    .NUM_PLAYERS     (NP),
    .ADDR_WIDTH      (13),
    .BTN_WIDTH       (BW),
    .SPRITE_WORDS    (SW),
    .GPIO_OUT_WIDTH  (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .wren        (wren),
    .data_out    (data_out),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .gpio        (gpio),
    .gpio_out    (gpio_out),
    .vsync       (vsync),
    .player_vga  (player_vga),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < SW; w++) begin
        m_shadow[p][w] = '0;
        m_active[p][w] = '0;
      end
    m_pending = 1'b0;
    m_frame   = '0;
    m_gpo     = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] ofs);
    int p, w;
    if (ofs < 8'h80) begin
      p = ofs / 8;
      w = ofs % 8;
      if (p < NP && w < SW) return m_shadow[p][w];
      return '0;
    end
    if (ofs < 8'h80 + NP) return 32'(m_btn[ofs - 8'h80]);
    case (ofs)
      8'hC0:   return m_frame;
      8'hC1:   return {29'b0, m_gpo};
      8'hC2:   return {31'b0, m_pending};
      default: return '0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] ofs, input logic [31:0] d);
    int p, w;
    if (ofs < 8'h80) begin
      p = ofs / 8;
      w = ofs % 8;
      if (p < NP && w < SW) m_shadow[p][w] = d;
    end else if (ofs == 8'hC1) begin
      m_gpo = d[2:0];
    end else if (ofs == 8'hC2 && d[0]) begin
      m_pending = 1'b1;
    end
  endtask

  task automatic model_rise();
    m_frame = m_frame + 1;
    if (m_pending) begin
      for (int p = 0; p < NP; p++)
        for (int w = 0; w < SW; w++) m_active[p][w] = m_shadow[p][w];
      m_pending = 1'b0;
    end
  endtask

  function automatic logic [255:0] exp_vga();
    logic [255:0] v = '0;
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < SW; w++) v[(p*SW+w)*32 +: 32] = m_active[p][w];
    return v;
  endfunction

  task automatic io_write(input logic [7:0] ofs, input logic [31:0] d);
    @(negedge clk);
    address = {5'b10000, ofs};
    data_in = d;
    wren    = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0;
    model_write(ofs, d);
  endtask

  task automatic io_read(input logic [7:0] ofs, input string tag);
    @(negedge clk);
    address = {5'b10000, ofs};
    wren    = 1'b0;
    @(posedge clk); #1;
    check(tag, 256'(data_out), 256'(model_read(ofs)));
  endtask

  task automatic vsync_pulse(input bit do_wr, input logic [7:0] ofs, input logic [31:0] d);
    @(negedge clk);
    wren  = 1'b0;
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("frame_pre_edge", 256'(frame_count), 256'(m_frame));
    @(negedge clk);
    if (do_wr) begin
      address = {5'b10000, ofs};
      data_in = d;
      wren    = 1'b1;
    end
    @(posedge clk); #1;
    wren = 1'b0;
    model_rise();
    if (do_wr) model_write(ofs, d);
    check("frame_on_edge", 256'(frame_count), 256'(m_frame));
    check("vga_on_edge", player_vga, exp_vga());
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("frame_settle", 256'(frame_count), 256'(m_frame));
  endtask

  initial begin
    logic [31:0] rq;
    logic [7:0]  rofs;
    int          sel;

    reset   = 1'b1;
    address = '0;
    data_in = '0;
    wren    = 1'b0;
    ram_q   = '0;
    gpio    = '1;
    vsync   = 1'b0;
    for (int p = 0; p < NP; p++) m_btn[p] = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 256'(data_out), 256'(0));
    check("rst_vga", player_vga, '0);
    check("rst_frame", 256'(frame_count), 256'(0));
    check("rst_gpio_out", 256'(gpio_out), 256'(0));
    @(negedge clk) reset = 1'b0;

    io_read(8'hC0, "rd_frame_after_rst");
    io_read(8'hC2, "rd_pending_after_rst");
    io_read(8'h80, "rd_btn_after_rst");

    io_write(8'h09, 32'h12345678);
    check("vga_no_commit", player_vga, exp_vga());
    io_read(8'h09, "rd_shadow_p1w1");
    io_write(8'hC2, 32'h1);
    io_read(8'hC2, "rd_pending_set");
    vsync_pulse(1'b0, 8'h00, '0);
    check("vga_p1w1", 256'(player_vga[(1*SW+1)*32 +: 32]), 256'(32'h12345678));
    io_read(8'hC2, "rd_pending_clear");
    io_read(8'hC0, "rd_frame_1");

    // Commit landing on the vsync edge must wait for the next edge.
    io_write(8'h09, 32'hCAFEBABE);
    vsync_pulse(1'b1, 8'hC2, 32'h1);
    io_read(8'hC2, "rd_pending_after_race");
    vsync_pulse(1'b0, 8'h00, '0);
    check("vga_after_race", 256'(player_vga[(1*SW+1)*32 +: 32]), 256'(32'hCAFEBABE));

    // Shadow write on the transfer edge is excluded from that transfer.
    io_write(8'h02, 32'hAAAA5555);
    io_write(8'hC2, 32'h1);
    vsync_pulse(1'b1, 8'h02, 32'h0BADF00D);
    io_read(8'h02, "rd_shadow_after_race");

    // RAM pass-through and GPIO output.
    @(negedge clk);
    rq      = $urandom;
    ram_q   = rq;
    address = 13'h0005;
    data_in = $urandom;
    wren    = 1'b1;
    #1;
    check("ram_wren_ram", 256'(ram_wren), 256'(1));
    @(posedge clk); #1;
    check("ram_q_pass", 256'(data_out), 256'(rq));
    @(negedge clk);
    address = 13'h10C1;
    data_in = 32'hFF;
    wren    = 1'b1;
    #1;
    check("ram_wren_io", 256'(ram_wren), 256'(0));
    @(posedge clk); #1;
    wren = 1'b0;
    model_write(8'hC1, 32'hFF);
    check("gpio_out_ff", 256'(gpio_out), 256'(3'b111));

    // Debounce: short glitch rejected, held press accepted after 2 + 4 edges.
    @(negedge clk);
    address = 13'h1080;
    gpio[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check("deb_glitch", 256'(data_out), 256'(0));
      if (i == 3) @(negedge clk) gpio[0] = 1'b1;
    end
    @(negedge clk) gpio[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("deb_press", 256'(data_out), 256'((i >= 7) ? 1 : 0));
    end
    m_btn[0] = 16'h0001;
    io_read(8'h80, "rd_btn_pressed");
    io_read(8'h81, "rd_btn_p1");
    @(negedge clk) begin
      address = 13'h1080;
      gpio[0] = 1'b1;
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("deb_release", 256'(data_out), 256'((i >= 7) ? 0 : 1));
    end
    m_btn[0] = '0;

    // Randomized traffic against the map model.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       rofs = 8'($urandom_range(0, 31));
        1:       rofs = 8'($urandom_range(8'hC0, 8'hC4));
        2:       rofs = 8'($urandom_range(8'h7E, 8'h83));
        default: rofs = 8'($urandom_range(0, 255));
      endcase
      if (sel < 4) io_write(rofs, $urandom);
      else if (sel < 8) io_read(rofs, "rand_read");
      else vsync_pulse(1'($urandom_range(0, 1)), rofs, $urandom);
    end

    // Reset with a commit pending discards it.
    io_write(8'h0B, 32'h13579BDF);
    io_write(8'hC2, 32'h1);
    vsync_pulse(1'b0, 8'h00, '0);
    io_write(8'h00, 32'h2468ACE0);
    io_write(8'hC2, 32'h1);
    io_read(8'hC2, "rd_pending_before_rst");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("vga_after_rst", player_vga, exp_vga());
    check("data_out_in_rst", 256'(data_out), 256'(0));
    @(negedge clk) reset = 1'b0;
    io_read(8'hC2, "rd_pending_after_rst2");
    io_write(8'h00, 32'hDEADBEEF);
    vsync_pulse(1'b0, 8'h00, '0);
    check("vga_no_xfer_after_rst", player_vga, '0);
    io_read(8'hC0, "rd_frame_after_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
